serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised bit-serial adder/subtractor: the multi-bit successor to the lab's single-bit serial-adder FSM (inputs a/b, outputs q/state). It accepts two WIDTH-bit operands on a start pulse and processes them LSB-first, one bit per clock, through a one-bit carry state register. It then presents the parallel result with carry-out and signed-overflow flags and a one-cycle done pulse. It sits beside the lab ALU blocks as a low-area arithmetic unit, with its serial bit and carry exposed for waveform inspection.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only while busy=0.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a_in  in  WIDTH  operand A; sampled with start.
- b_in  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result; held until the next accepted start.
- cout  out  1  carry out of the MSB (for subtraction, 1 = no borrow).
- ovf  out  1  signed overflow (carry into the MSB XOR carry out).
- q  out  1  current serial sum bit; 0 when idle.
- state  out  1  carry register contents.

## Operation
- FSM has two states. IDLE: busy=0. RUN: busy=1.
- IDLE -> RUN when start=1 at a clock edge. At that edge:
  - A is loaded into a shift register.
  - B is loaded, inverted if sub=1.
  - carry (state) is loaded with sub.
  - the bit counter is cleared to 0.
  - sum, cout and ovf are not changed.
- In RUN, each edge:
  - q = a_sh[0] ^ b_sh[0] ^ carry is shifted into the MSB of a result shift register.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - both operand registers shift right by one.
  - the counter increments.
- On the edge that processes bit WIDTH-1:
  - sum <= final result word.
  - cout <= final carry.
  - ovf <= carry-into-MSB ^ final carry.
  - done <= 1, busy <= 0, FSM returns to IDLE.
- q is combinational from the registers while busy=1, and forced to 0 in IDLE.
- start while busy=1 is ignored. It is not queued.
- start in the cycle where done=1 is accepted normally. done falls at that edge.
- WIDTH=1 is a valid configuration: one RUN cycle, and ovf = cin ^ cout.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=0, q=0, FSM=IDLE.
- Reset is asynchronous in both directions. Asserting it mid-RUN aborts the operation immediately, with no done pulse and all outputs at their reset values.
- Let E0 be the edge where start is accepted:
  - busy=1 from E0 through EWIDTH.
  - the bits are processed at edges E1..EWIDTH.
  - done=1 and sum/cout/ovf are valid after EWIDTH, for one cycle.
  - done=0 after E(WIDTH+1).
- Latency from the start-accepting edge to done: WIDTH cycles.
- Back-to-back throughput is one result per WIDTH+1 cycles.
- sum, cout and ovf hold their last values from done until the next done, or until reset.

## Configuration
- SERIAL_ADDSUB_SAT_EN defined: when ovf=1, sum is replaced by the signed saturation limit. That is 0111…1 if the true result is positive (final carry=0), else 1000…0. cout and ovf are reported unchanged.
- Not defined: sum is the wrapped modulo-2^WIDTH result.
- The macro affects only the value registered into sum on the final RUN edge. Latency and handshake are identical in both builds.

## Test plan
- WIDTH=8, 0x35+0x4A -> after 8 cycles done=1, sum=0x7F, cout=0, ovf=0. The q sequence LSB-first is 1,1,1,1,1,1,1,0.
- 0x7F+0x01 -> sum=0x80, ovf=1, cout=0. With SERIAL_ADDSUB_SAT_EN: sum=0x7F, ovf=1.
- sub=1, 0x10-0x20 -> sum=0xF0, cout=0, ovf=0. Then 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
- Pulse start again during RUN with different operands -> ignored. Exactly one done, with the first operands' result. Start held during the done cycle -> new operation begins at that edge.
- Drop rst_n after 3 RUN cycles -> busy, done, sum, state and q all go to 0 immediately, with no done pulse. The next start completes correctly.
- WIDTH=1 instance: 1+1 -> sum=0, cout=1, ovf=1, with done on the cycle after start.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: processes WIDTH-bit operands LSB-first, one bit per clock.
// Optional build macro SERIAL_ADDSUB_SAT_EN: saturate sum to the signed limit on overflow.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             q,
  output logic             state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             bit_sum;
  logic             carry_next;
  logic             ovf_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_next;

  // Shift-based result assembly avoids a zero-width slice when WIDTH is 1.
  always_comb begin
    bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
    carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    ovf_next   = carry ^ carry_next;
    last_bit   = (cnt == CW'(WIDTH - 1));
    res_next   = (res_sh >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ovf_next)
      sum_next = carry_next ? (WIDTH'(1) << (WIDTH - 1)) : ~(WIDTH'(1) << (WIDTH - 1));
    else
      sum_next = res_next;
`else
    sum_next   = res_next;
`endif
  end

  assign busy  = (fsm == RUN);
  assign q     = busy & bit_sum;
  assign state = carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= sub ? ~b_in : b_in;
            carry <= sub;
            cnt   <= '0;
            fsm   <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= carry_next;
          if (last_bit) begin
            sum  <= sum_next;
            cout <= carry_next;
            ovf  <= ovf_next;
            done <= 1'b1;
            fsm  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub: WIDTH=8 and WIDTH=1 instances on one clock.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, sub8, busy8, done8, cout8, ovf8, q8, state8;
  logic [7:0] a8, b8, sum8;
  logic       start1, sub1, busy1, done1, cout1, ovf1, q1, state1;
  logic [0:0] a1, b1, sum1;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .q(q8), .state(state8)
  );

  serial_addsub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1), .q(q1), .state(state1)
  );

  // Drives a one-cycle start on the 8-bit unit; returns at the falling edge after E0.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    checks++; if (busy8 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy8); end
    checks++; if (done8 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done8); end
    checks++; if (sum8 !== 8'h00)  begin errors++; $display("[TB] FAIL reset_sum: got %h expected 00", sum8); end
    checks++; if (cout8 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_cout: got %b expected 0", cout8); end
    checks++; if (ovf8 !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf8); end
    checks++; if (state8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_state: got %b expected 0", state8); end
    checks++; if (q8 !== 1'b0)     begin errors++; $display("[TB] FAIL reset_q: got %b expected 0", q8); end
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_w1: got busy=%b done=%b sum=%b expected 0 0 0", busy1, done1, sum1); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic;
    logic [7:0] exp_q;
    exp_q = 8'h7F;
    launch8(8'h35, 8'h4A, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL add_busy[%0d]: got %b expected 1", i, busy8); end
      checks++; if (q8 !== exp_q[i]) begin errors++; $display("[TB] FAIL add_q[%0d]: got %b expected %b", i, q8, exp_q[i]); end
    end
    @(negedge clk);
    checks++; if (done8 !== 1'b1) begin errors++; $display("[TB] FAIL add_done: got %b expected 1", done8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL add_busy_end: got %b expected 0", busy8); end
    checks++; if (sum8 !== 8'h7F) begin errors++; $display("[TB] FAIL add_sum: got %h expected 7f", sum8); end
    checks++; if (cout8 !== 1'b0 || ovf8 !== 1'b0) begin errors++; $display("[TB] FAIL add_flags: got cout=%b ovf=%b expected 0 0", cout8, ovf8); end
    checks++; if (q8 !== 1'b0) begin errors++; $display("[TB] FAIL add_q_idle: got %b expected 0", q8); end
    @(negedge clk);
    checks++; if (done8 !== 1'b0) begin errors++; $display("[TB] FAIL add_done_drop: got %b expected 0", done8); end
    checks++; if (sum8 !== 8'h7F) begin errors++; $display("[TB] FAIL add_sum_hold: got %h expected 7f", sum8); end
  endtask

  task automatic test_overflow;
    launch8(8'h7F, 8'h01, 1'b0);
    repeat (8) @(negedge clk);
    checks++; if (done8 !== 1'b1) begin errors++; $display("[TB] FAIL povf_done: got %b expected 1", done8); end
    checks++; if (sum8 !== (SAT ? 8'h7F : 8'h80)) begin errors++; $display("[TB] FAIL povf_sum: got %h expected %h", sum8, SAT ? 8'h7F : 8'h80); end
    checks++; if (ovf8 !== 1'b1 || cout8 !== 1'b0) begin errors++; $display("[TB] FAIL povf_flags: got ovf=%b cout=%b expected 1 0", ovf8, cout8); end
    launch8(8'h80, 8'h01, 1'b1);
    repeat (8) @(negedge clk);
    checks++; if (sum8 !== (SAT ? 8'h80 : 8'h7F)) begin errors++; $display("[TB] FAIL novf_sum: got %h expected %h", sum8, SAT ? 8'h80 : 8'h7F); end
    checks++; if (ovf8 !== 1'b1 || cout8 !== 1'b1) begin errors++; $display("[TB] FAIL novf_flags: got ovf=%b cout=%b expected 1 1", ovf8, cout8); end
  endtask

  task automatic test_sub;
    launch8(8'h10, 8'h20, 1'b1);
    checks++; if (state8 !== 1'b1) begin errors++; $display("[TB] FAIL sub_cin: got %b expected 1", state8); end
    repeat (8) @(negedge clk);
    checks++; if (done8 !== 1'b1) begin errors++; $display("[TB] FAIL sub_done: got %b expected 1", done8); end
    checks++; if (sum8 !== 8'hF0) begin errors++; $display("[TB] FAIL sub_sum: got %h expected f0", sum8); end
    checks++; if (cout8 !== 1'b0 || ovf8 !== 1'b0) begin errors++; $display("[TB] FAIL sub_flags: got cout=%b ovf=%b expected 0 0", cout8, ovf8); end
    launch8(8'hFF, 8'h01, 1'b0);
    repeat (8) @(negedge clk);
    checks++; if (sum8 !== 8'h00) begin errors++; $display("[TB] FAIL wrap_sum: got %h expected 00", sum8); end
    checks++; if (cout8 !== 1'b1 || ovf8 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_flags: got cout=%b ovf=%b expected 1 0", cout8, ovf8); end
  endtask

  task automatic test_back_to_back;
    int nd;
    nd = 0;
    launch8(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    if (done8) nd++;
    repeat (4) begin
      @(negedge clk);
      if (done8) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("[TB] FAIL ignore_early_done: got %0d expected 0", nd); end
    @(negedge clk);
    checks++; if (done8 !== 1'b1) begin errors++; $display("[TB] FAIL ignore_done: got %b expected 1", done8); end
    checks++; if (sum8 !== 8'h46) begin errors++; $display("[TB] FAIL ignore_sum: got %h expected 46", sum8); end
    a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy8, done8); end
    nd = 0;
    repeat (7) begin
      @(negedge clk);
      if (done8) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("[TB] FAIL b2b_early_done: got %0d expected 0", nd); end
    @(negedge clk);
    checks++; if (done8 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done: got %b expected 1", done8); end
    checks++; if (sum8 !== 8'h03) begin errors++; $display("[TB] FAIL b2b_sum: got %h expected 03", sum8); end
  endtask

  task automatic test_reset_abort;
    int nd;
    nd = 0;
    launch8(8'hFF, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (state8 !== 1'b1 || busy8 !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre: got state=%b busy=%b expected 1 1", state8, busy8); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy8 !== 1'b0)  begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy8); end
    checks++; if (done8 !== 1'b0)  begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", done8); end
    checks++; if (sum8 !== 8'h00)  begin errors++; $display("[TB] FAIL abort_sum: got %h expected 00", sum8); end
    checks++; if (state8 !== 1'b0) begin errors++; $display("[TB] FAIL abort_state: got %b expected 0", state8); end
    checks++; if (q8 !== 1'b0)     begin errors++; $display("[TB] FAIL abort_q: got %b expected 0", q8); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", nd); end
    launch8(8'h05, 8'h03, 1'b0);
    repeat (8) @(negedge clk);
    checks++; if (done8 !== 1'b1 || sum8 !== 8'h08) begin errors++; $display("[TB] FAIL abort_recover: got done=%b sum=%h expected 1 08", done8, sum8); end
  endtask

  task automatic test_width1;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("[TB] FAIL w1_busy: got busy=%b done=%b expected 1 0", busy1, done1); end
    @(negedge clk);
    checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("[TB] FAIL w1_done: got done=%b busy=%b expected 1 0", done1, busy1); end
    checks++; if (sum1 !== (SAT ? 1'b1 : 1'b0)) begin errors++; $display("[TB] FAIL w1_sum: got %b expected %b", sum1, SAT ? 1'b1 : 1'b0); end
    checks++; if (cout1 !== 1'b1 || ovf1 !== 1'b1) begin errors++; $display("[TB] FAIL w1_flags: got cout=%b ovf=%b expected 1 1", cout1, ovf1); end
    @(negedge clk);
    checks++; if (done1 !== 1'b0) begin errors++; $display("[TB] FAIL w1_done_drop: got %b expected 0", done1); end
    a1 = 1'b0; b1 = 1'b1; sub1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++; if (q1 !== 1'b1 || state1 !== 1'b1) begin errors++; $display("[TB] FAIL w1_sub_q: got q=%b state=%b expected 1 1", q1, state1); end
    @(negedge clk);
    checks++; if (sum1 !== (SAT ? 1'b0 : 1'b1)) begin errors++; $display("[TB] FAIL w1_sub_sum: got %b expected %b", sum1, SAT ? 1'b0 : 1'b1); end
    checks++; if (cout1 !== 1'b0 || ovf1 !== 1'b1) begin errors++; $display("[TB] FAIL w1_sub_flags: got cout=%b ovf=%b expected 0 1", cout1, ovf1); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    test_reset();
    test_add_basic();
    test_overflow();
    test_sub();
    test_back_to_back();
    test_reset_abort();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
